// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clk cycles and reports the count once per window.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq_out,
  output logic             valid,
  output logic             ovf
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sync_q, sync_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             rise;
  logic [CNT_W-1:0] edge_cnt_inc;
  logic             sat_inc;

  assign rise = sync_q[1] & ~sync_q[2];

  // The result registers load on the way into DONE so that freq_out, ovf and
  // valid are all presented together during the single DONE cycle.
  always_comb begin
    sync_d       = {sync_q[1:0], sig_in};
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_d       = freq_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    edge_cnt_inc = (rise && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    sat_inc      = sat_q | (rise && (edge_cnt_q == CNT_MAX));

    case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d    = MEASURE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MEASURE: begin
        edge_cnt_d = edge_cnt_inc;
        sat_d      = sat_inc;
        if (gate_cnt_q == GATE_LAST) begin
          state_d = DONE;
          freq_d  = edge_cnt_inc;
          ovf_d   = sat_inc;
          valid_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          busy_d     = 1'b1;
        end
      end
      DONE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (cont) begin
          state_d = MEASURE;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;

endmodule
